// File: rtl/sha256_mem_arbiter.sv
// sha256_mem_arbiter
// Round-robin arbiter that shares one synchronous SRAM port among NUM_REQ
// SHA-256 cores. At most one word access is granted per cycle. Each read's
// data is routed back to the core that issued it, READ_LAT cycles after the
// grant.
//
// Optional build macro: SHA_ARB_LOCK_EN
//   When defined, a req_lock input lets the core that currently owns the bus
//   keep its grant every cycle. This supports uninterrupted burst reads.
//   When undefined, arbitration is pure per-cycle round-robin.
module sha256_mem_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
`ifdef SHA_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]          req_lock,
`endif
  output logic [NUM_REQ-1:0]          req_gnt,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        mem_clk,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_write_data,
  input  logic [DATA_W-1:0]           mem_read_data,
  output logic                        busy
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDXW:0]   NUM_REQ_EXT = (IDXW+1)'(NUM_REQ);
  localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(NUM_REQ - 1);

  // Round-robin priority pointer: the core scanned first this cycle
  logic [IDXW-1:0]                r_ptr;
  // Read response pipeline: one valid bit and one issuer index per stage
  logic [READ_LAT-1:0]            r_pipeValid;
  logic [READ_LAT-1:0][IDXW-1:0]  r_pipeIdx;

  logic            w_found;
  logic            w_advance;
  logic [IDXW-1:0] w_winner;
  logic [IDXW:0]   w_cand;
  logic            w_readGrant;

`ifdef SHA_ARB_LOCK_EN
  // Last granted core and whether a grant actually happened last cycle
  logic [IDXW-1:0] r_owner;
  logic            r_ownerValid;
  logic            w_locked;
`endif

  // Pick this cycle's winner: a locked owner keeps the bus, otherwise scan from the pointer
  always_comb begin
    w_found   = 1'b0;
    w_winner  = '0;
    w_cand    = '0;
    w_advance = 1'b0;
`ifdef SHA_ARB_LOCK_EN
    w_locked = r_ownerValid && req_valid[r_owner] && req_lock[r_owner];
    if (w_locked) begin
      w_found  = 1'b1;
      w_winner = r_owner;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + (IDXW+1)'(k);
      if (w_cand >= NUM_REQ_EXT) begin
        w_cand = w_cand - NUM_REQ_EXT;
      end
      if (!w_found && req_valid[w_cand[IDXW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[IDXW-1:0];
      end
    end
    // Nothing may be granted while reset is held, even though requests may be up
    if (!reset_n) begin
      w_found = 1'b0;
    end
`ifdef SHA_ARB_LOCK_EN
    w_advance = w_found && !w_locked;
`else
    w_advance = w_found;
`endif
  end

  // Route the winner onto the memory port; unselected cores' buses never leak through
  always_comb begin
    req_gnt        = '0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_found && (w_winner == IDXW'(i))) begin
        req_gnt[i]     = 1'b1;
        mem_we         = req_we[i];
        mem_addr       = req_addr[i*ADDR_W +: ADDR_W];
        mem_write_data = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_readGrant = w_found && !mem_we;

  // Move the pointer just past the winner on every normal grant; hold it otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (w_advance) begin
      r_ptr <= (w_winner == LAST_IDX) ? '0 : w_winner + IDXW'(1);
    end
  end

`ifdef SHA_ARB_LOCK_EN
  // Remember who held the bus last cycle so a lock can be honoured
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner      <= '0;
      r_ownerValid <= 1'b0;
    end else begin
      r_ownerValid <= w_found;
      if (w_found) begin
        r_owner <= w_winner;
      end
    end
  end
`endif

  // Carry each granted read's issuer down the pipe so its data returns to it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pipeValid <= '0;
      r_pipeIdx   <= '0;
    end else begin
      r_pipeValid[0] <= w_readGrant;
      r_pipeIdx[0]   <= w_winner;
      for (int s = 1; s < READ_LAT; s++) begin
        r_pipeValid[s] <= r_pipeValid[s-1];
        r_pipeIdx[s]   <= r_pipeIdx[s-1];
      end
    end
  end

  // Decode the last pipe stage into a one-hot response strobe
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_pipeValid[READ_LAT-1] && (r_pipeIdx[READ_LAT-1] == IDXW'(i))) begin
        rsp_valid[i] = 1'b1;
      end
    end
  end

  assign rsp_data = mem_read_data;
  assign mem_clk  = clk;
  assign busy     = reset_n && ((|req_valid) || (|r_pipeValid));

endmodule

// File: doc/sha256_mem_arbiter.md
Name: sha256_mem_arbiter

Overview:
Round-robin arbiter sharing the single synchronous dual-port SRAM port (mem_addr/mem_we/mem_write_data/mem_read_data) among NUM_REQ SHA-256 hash cores.
- Sits between the cores and the testbench/system memory.
- Grants at most one word access per cycle and routes each read's returned data back to its issuer after the fixed memory latency.
- Lets several hash cores fetch message words and write digests concurrently without a bus conflict.

Parameters:
NUM_REQ, 4, number of requesting cores (2..8)
ADDR_W, 16, word address width
DATA_W, 32, data word width
READ_LAT, 1, cycles from address presented to mem_read_data valid (1..4)

Ports:
clk  in  1  system clock; all state on posedge
reset_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-core access request, bit i = core i
req_we  in  NUM_REQ  per-core write enable (1 = write, 0 = read)
req_addr  in  NUM_REQ*ADDR_W  packed addresses, core i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data, core i at [i*DATA_W +: DATA_W]
req_gnt  out  NUM_REQ  one-hot grant; access accepted in the cycle it is high
rsp_valid  out  NUM_REQ  one-hot; read data for core i is on rsp_data
rsp_data  out  DATA_W  mem_read_data forwarded
mem_clk  out  1  equals clk
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_write_data  out  DATA_W  memory write data
mem_read_data  in  DATA_W  memory read data
busy  out  1  high while any read is in flight or any request is asserted

Behaviour:
- Reset (async, reset_n low):
  - Priority pointer = 0; response pipeline cleared; rsp_valid = 0.
  - req_gnt = 0, mem_we = 0, mem_addr = 0, mem_write_data = 0.
  - Reads in flight at reset are discarded; no rsp_valid ever fires for them.
- Arbitration is combinational within a cycle:
  - Scan req_valid starting at the pointer, ascending modulo NUM_REQ.
  - The first set bit wins and its req_gnt bit is high in that same cycle.
- Memory mux:
  - mem_addr, mem_we and mem_write_data come from the winner.
  - With no winner: mem_we = 0, mem_addr = 0, mem_write_data = 0.
- Pointer update on posedge when a grant occurs: pointer <= winner+1 (wraps NUM_REQ-1 -> 0). No grant: pointer holds.
- Handshake:
  - A core holds req_valid/we/addr/wdata stable until it sees req_gnt. The transfer completes in the grant cycle.
  - The core may drop or change its request the next cycle.
  - Dropping req_valid before grant withdraws the request; no side effects.
- Writes: memory captures on the posedge ending the grant cycle. No response is generated.
- Reads: winner index is pushed into a READ_LAT-deep valid+index shift pipeline. rsp_valid[idx] = 1 exactly READ_LAT cycles after the grant cycle, with rsp_data = mem_read_data.
- Back-to-back reads from different cores return in grant order, one per cycle, with no bubbles.
- rsp_data is always mem_read_data; it is meaningful only when rsp_valid != 0.
- Single requester repeatedly requesting: granted every cycle (full throughput).
- All NUM_REQ requesting continuously: grants rotate 0,1,2,...,NUM_REQ-1,0. No core waits more than NUM_REQ-1 cycles.
- Simultaneous grant and response in one cycle is normal and independent.
- X on an unrequested core's addr/wdata must never reach the mem_* outputs.

Optional Feature:
SHA_ARB_LOCK_EN
- Defined:
  - Adds input port req_lock [NUM_REQ].
  - While the current owner has req_valid and req_lock both high, it keeps the grant every cycle, whatever the other requests are.
  - The pointer does not advance during lock.
  - When the owner deasserts lock or req_valid, normal round-robin resumes from owner+1.
  - Lock asserted by a non-granted core has no effect until that core wins normally.
  - Purpose: a core reads its 16-word block as an uninterrupted burst.
- Undefined: no req_lock port; pure per-cycle round-robin.

Test Plan:
- Reset, then idle cycles -> req_gnt=0, mem_we=0, mem_addr=0x0000, rsp_valid=0, busy=0.
- Core 2 alone reads addr 0x0010 with memory word 0xDEADBEEF, READ_LAT=1 -> req_gnt=4'b0100 in the request cycle; next cycle rsp_valid=4'b0100, rsp_data=0xDEADBEEF.
- All 4 cores hold read requests for 8 cycles from reset -> grant sequence 0,1,2,3,0,1,2,3; rsp_valid follows one cycle later in the same order.
- Core 1 writes 0x6A09E667 to 0x0200 while core 3 reads 0x0200, with core 1 at higher priority -> core 1 granted first; core 3 granted next cycle and receives 0x6A09E667.
- Reads outstanding with READ_LAT=3 and reset_n pulsed low mid-flight -> all outputs return to reset values immediately; no rsp_valid after release; pointer restarts at core 0.
- SHA_ARB_LOCK_EN: core 0 locks for 16 reads while cores 1–3 request -> 16 consecutive grants to core 0; then core 1 is granted; with the macro undefined, grants interleave 0,1,2,3.
